// File: rtl/gpio_bank.sv
// Parametrised GPIO register bank: per-port OUT/OE/IN/edge-interrupt registers
// behind a byte-wide register interface, driving and sampling flat pin buses.
module gpio_bank #(
  parameter int NPORTS = 8,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic                    Clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       Addr,
  input  logic [WIDTH-1:0]        WData,
  input  logic                    WEn,
  output logic [WIDTH-1:0]        RData,
  input  logic [NPORTS*WIDTH-1:0] Pin_In,
  output logic [NPORTS*WIDTH-1:0] Pin_Out,
  output logic [NPORTS*WIDTH-1:0] Pin_OE,
  output logic                    Irq
);

  localparam int PIDX_W = ADDR_W - 3;
  localparam int NB     = NPORTS * WIDTH;

  logic [2:0]        reg_sel;
  logic [PIDX_W-1:0] port_idx;

  logic [NB-1:0] out_q, out_d;
  logic [NB-1:0] oe_q, oe_d;
  logic [NB-1:0] rise_en_q, rise_en_d;
  logic [NB-1:0] fall_en_q, fall_en_d;
  logic [NB-1:0] status_q, status_d;
  logic [NB-1:0] s1_q, s1_d;
  logic [NB-1:0] s2_q, s2_d;
  logic [NB-1:0] s3_q, s3_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic [NB-1:0] rise, fall, clr;

  assign reg_sel  = Addr[2:0];
  assign port_idx = Addr[ADDR_W-1:3];

  // Port indices >= NPORTS match no loop iteration, so they never alias a real port.
  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr       = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (WEn && (port_idx == PIDX_W'(p))) begin
        case (reg_sel)
          3'd0: out_d[p*WIDTH +: WIDTH]     = WData;
          3'd1: oe_d[p*WIDTH +: WIDTH]      = WData;
          3'd3: rise_en_d[p*WIDTH +: WIDTH] = WData;
          3'd4: fall_en_d[p*WIDTH +: WIDTH] = WData;
          3'd5: clr[p*WIDTH +: WIDTH]       = WData;
          3'd6: out_d[p*WIDTH +: WIDTH]     = out_q[p*WIDTH +: WIDTH] ^ WData;
          default: ;
        endcase
      end
    end
  end

  // Sets are ORed in after the clear so a coincident edge keeps the bit set.
  always_comb begin
    s1_d     = Pin_In;
    s2_d     = s1_q;
    s3_d     = s2_q;
    rise     = s2_q & ~s3_q;
    fall     = ~s2_q & s3_q;
    status_d = (status_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  always_comb begin
    rdata_d = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (port_idx == PIDX_W'(p)) begin
        case (reg_sel)
          3'd0:    rdata_d = out_q[p*WIDTH +: WIDTH];
          3'd1:    rdata_d = oe_q[p*WIDTH +: WIDTH];
          3'd2:    rdata_d = s2_q[p*WIDTH +: WIDTH];
          3'd3:    rdata_d = rise_en_q[p*WIDTH +: WIDTH];
          3'd4:    rdata_d = fall_en_q[p*WIDTH +: WIDTH];
          3'd5:    rdata_d = status_q[p*WIDTH +: WIDTH];
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      rdata_q   <= rdata_d;
    end
  end

  assign RData   = rdata_q;
  assign Pin_Out = out_q;
  assign Pin_OE  = oe_q;
  assign Irq     = |status_q;

endmodule
